// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// Holds the sequencer state encoding and the shared counter width calculation.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN
   } state_t;

   // Width of a down-counter that must hold (max cycle count - 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
// Latency is STAGES cycles; there is no handshake and no backpressure.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset and system reset from the PLL lock indication (oscillator domain).
// Lock to sys_reset release is SYNC_STAGES+1+STABLE_CYCLES cycles; no flow control.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic             sys_reset,
   output logic             ready,
   output logic [CNT_W-1:0] retry_count,
   output logic [CNT_W-1:0] loss_count
);

   localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

   localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LOAD     = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES - 1);

   logic          lock_s;
   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          retry_inc;
   logic          loss_inc;

   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk  (clk),
      .reset(reset),
      .d    (pll_locked),
      .q    (lock_s)
   );

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt - CW'(1);
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      case (state)
         PLL_RST: begin
            if (cnt == '0) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = TO_LOAD;
            end
         end
         WAIT_LOCK: begin
            // Lock takes priority over a timeout expiring on the same cycle.
            if (lock_s) begin
               state_nx = STABLE;
               cnt_nx   = STABLE_LOAD;
            end else if (cnt == '0) begin
               state_nx  = PLL_RST;
               cnt_nx    = RST_LOAD;
               retry_inc = 1'b1;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_nx = WAIT_LOCK;
               cnt_nx   = TO_LOAD;
            end else if (cnt == '0) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end
         end
         RUN: begin
            cnt_nx = cnt;
            if (!lock_s) begin
               state_nx = PLL_RST;
               cnt_nx   = RST_LOAD;
               loss_inc = 1'b1;
            end
         end
         default: begin
            state_nx = PLL_RST;
            cnt_nx   = RST_LOAD;
         end
      endcase
   end

   // Reset counts as an entry into PLL_RST, so the pulse timing from reset
   // release matches a pulse triggered by a timeout or a lock loss.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= PLL_RST;
         cnt         <= RST_LOAD;
         pll_rst     <= 1'b1;
         sys_reset   <= 1'b1;
         ready       <= 1'b0;
         retry_count <= '0;
         loss_count  <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         pll_rst   <= (state_nx == PLL_RST);
         sys_reset <= (state_nx != RUN);
         ready     <= (state_nx == RUN);
         if (retry_inc && (retry_count != '1)) begin
            retry_count <= retry_count + CNT_W'(1);
         end
         if (loss_inc && (loss_count != '1)) begin
            loss_count <= loss_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table, hand sequences and a random run
// checked every cycle against an elapsed-time reference model.
module tb_pll_reset_sequencer;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int SYNC_STAGES   = 2;

   localparam int MP_RST    = 0;
   localparam int MP_WAIT   = 1;
   localparam int MP_STABLE = 2;
   localparam int MP_RUN    = 3;

   logic       clk;
   logic       reset;
   logic       pll_locked;
   logic       pll_rst,   sys_reset,   ready;
   logic [7:0] retry_count, loss_count;
   logic       pll_rst2,  sys_reset2,  ready2;
   logic [1:0] retry_count2, loss_count2;

   int checks = 0;
   int errors = 0;
   int k      = 0;

   int m_phase;
   int m_el;
   int m_retry;
   int m_loss;
   bit [SYNC_STAGES-1:0] m_hist;

   pll_reset_sequencer #(
      .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .pll_locked(pll_locked),
      .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready),
      .retry_count(retry_count), .loss_count(loss_count)
   );

   pll_reset_sequencer #(
      .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .CNT_W(2)
   ) dut_sat (
      .clk(clk), .reset(reset), .pll_locked(pll_locked),
      .pll_rst(pll_rst2), .sys_reset(sys_reset2), .ready(ready2),
      .retry_count(retry_count2), .loss_count(loss_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Reference: lock_s is the raw input delayed SYNC_STAGES edges; each phase
   // is left once enough cycles have elapsed in it, per the behavioural rules.
   task automatic model_step(input bit r, input bit l);
      bit ls;
      if (r) begin
         m_phase = MP_RST;
         m_el    = 0;
         m_retry = 0;
         m_loss  = 0;
         m_hist  = '0;
      end else begin
         ls = m_hist[SYNC_STAGES-1];
         m_el++;
         case (m_phase)
            MP_RST: if (m_el >= RST_CYCLES) begin m_phase = MP_WAIT; m_el = 0; end
            MP_WAIT: begin
               if (ls) begin
                  m_phase = MP_STABLE; m_el = 0;
               end else if (m_el >= LOCK_TIMEOUT) begin
                  m_phase = MP_RST; m_el = 0; m_retry++;
               end
            end
            MP_STABLE: begin
               if (!ls) begin
                  m_phase = MP_WAIT; m_el = 0;
               end else if (m_el >= STABLE_CYCLES) begin
                  m_phase = MP_RUN; m_el = 0;
               end
            end
            default: if (!ls) begin m_phase = MP_RST; m_el = 0; m_loss++; end
         endcase
         m_hist = {m_hist[SYNC_STAGES-2:0], l};
      end
   endtask

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit l);
      logic [25:0] act_v;
      logic [25:0] exp_v;
      @(negedge clk);
      reset      = r;
      pll_locked = l;
      @(posedge clk);
      model_step(r, l);
      k = r ? 0 : k + 1;
      #1;
      act_v = {pll_rst, sys_reset, ready, retry_count, loss_count,
               pll_rst2, sys_reset2, ready2, retry_count2, loss_count2};
      exp_v = {m_phase == MP_RST, m_phase != MP_RUN, m_phase == MP_RUN,
               8'(sat(m_retry, 255)), 8'(sat(m_loss, 255)),
               m_phase == MP_RST, m_phase != MP_RUN, m_phase == MP_RUN,
               2'(sat(m_retry, 3)), 2'(sat(m_loss, 3))};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL model k=%0d: got %h expected %h (t=%0t)", k, act_v, exp_v, $time);
      end
   endtask

   typedef struct {
      bit rst;
      bit lock;
      int hold;
      bit pr;
      bit sr;
      bit rd;
      int rc;
      int lc;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int pat_bad;
      int sys_bad;
      int left;
      bit lv;
      bit r;

      // Bring-up, loss in RUN and recovery; k counts edges after the last reset edge.
      tbl[0]  = '{1'b1, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0, 0};
      tbl[1]  = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0, 0};
      tbl[2]  = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 0};
      tbl[3]  = '{1'b0, 1'b0,  6, 1'b0, 1'b1, 1'b0, 0, 0};
      tbl[4]  = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 0, 0};
      tbl[5]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[6]  = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[7]  = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[8]  = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 0, 1};
      tbl[9]  = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0, 1};
      tbl[10] = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 1};
      tbl[11] = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 0, 1};
      tbl[12] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 0, 1};

      reset      = 1'b1;
      pll_locked = 1'b0;

      for (int i = 0; i < 13; i++) begin
         for (int j = 0; j < tbl[i].hold; j++) cyc(tbl[i].rst, tbl[i].lock);
         chk($sformatf("vec%0d pll_rst", i),     int'(pll_rst),     int'(tbl[i].pr));
         chk($sformatf("vec%0d sys_reset", i),   int'(sys_reset),   int'(tbl[i].sr));
         chk($sformatf("vec%0d ready", i),       int'(ready),       int'(tbl[i].rd));
         chk($sformatf("vec%0d retry_count", i), int'(retry_count), tbl[i].rc);
         chk($sformatf("vec%0d loss_count", i),  int'(loss_count),  tbl[i].lc);
      end

      // Lock never arrives: 4-cycle pll_rst pulse every 24 cycles.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
      pat_bad = 0;
      sys_bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b0);
         if (pll_rst !== ((k % 24) < 4)) pat_bad++;
         if (sys_reset !== 1'b1) sys_bad++;
      end
      chk("timeout pulse pattern errors", pat_bad, 0);
      chk("timeout sys_reset low cycles", sys_bad, 0);
      chk("timeout retry_count", int'(retry_count), 4);
      for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0);
      chk("six timeouts retry_count", int'(retry_count), 6);
      chk("saturated retry_count", int'(retry_count2), 3);

      // Into STABLE, then reset.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
      chk("stable pll_rst", int'(pll_rst), 0);
      chk("stable sys_reset", int'(sys_reset), 1);
      cyc(1'b1, 1'b1);
      chk("mid-stable reset pll_rst", int'(pll_rst), 1);
      chk("mid-stable reset sys_reset", int'(sys_reset), 1);
      chk("mid-stable reset ready", int'(ready), 0);
      chk("mid-stable reset retry_count", int'(retry_count), 0);
      chk("mid-stable reset retry_count sat", int'(retry_count2), 0);
      chk("mid-stable reset loss_count", int'(loss_count), 0);

      // Glitch in STABLE restarts the stability window.
      cyc(1'b1, 1'b0);
      for (int i = 1; i <= 5; i++)   cyc(1'b0, 1'b0);
      for (int i = 6; i <= 10; i++)  cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      for (int i = 12; i <= 16; i++) cyc(1'b0, 1'b1);
      chk("glitch no early run sys_reset", int'(sys_reset), 1);
      for (int i = 17; i <= 21; i++) cyc(1'b0, 1'b1);
      chk("glitch k21 sys_reset", int'(sys_reset), 1);
      cyc(1'b0, 1'b1);
      chk("glitch k22 sys_reset", int'(sys_reset), 0);
      chk("glitch k22 ready", int'(ready), 1);
      chk("glitch retry_count", int'(retry_count), 0);
      chk("glitch loss_count", int'(loss_count), 0);

      // Random lock activity with occasional resets.
      left = 0;
      lv   = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (left == 0) begin
            lv   = ~lv;
            left = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
         end
         r = ($urandom_range(0, 399) == 0);
         cyc(r, lv);
         left--;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
